// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the multi-cycle RV32I sequencer.
//   state_e   : sequencer stage encoding
//   NOP_INSTR : ADDI x0,x0,0; the instruction register holds this value after
//               reset, so the decoder always sees a legal, harmless instruction
//   XLEN_DEF  : default datapath / PC width
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_e;

endpackage

// File: rtl/mc_wait_timer.sv
// -----------------------------------------------------------------------------
// mc_wait_timer
// Counts cycles in which a memory request is outstanding without an ack and
// flags expiry on the cycle that would bring the count to MAX_WAIT.
// Ports:
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_clr    : clear the count (sequencer is changing state)
//   i_wait   : request high and ack low this cycle
//   o_expire : this wait cycle is the MAX_WAIT-th one without an ack
// -----------------------------------------------------------------------------
module mc_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_expire
);

    // Only values 0..MAX_WAIT-1 are ever held: reaching MAX_WAIT forces a state
    // change, which clears the count.
    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_wait) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign o_expire = i_wait & (cnt_q == LIMIT);

endmodule

// File: rtl/mc_core_seq.sv
// -----------------------------------------------------------------------------
// mc_core_seq
// Multi-cycle execution sequencer for the RV32I core. Owns the PC, the
// instruction register and the stage FSM, runs the req/ack handshakes with the
// instruction and data memories, gates the regfile write to the WB stage and
// publishes registered retire information.
//
// Stage flow: FETCH -> DECODE -> EXEC -> [MEM for legal loads/stores] -> WB
// -> FETCH. A memory request that waits MAX_WAIT cycles without an ack sends
// the sequencer to ERR, which only reset leaves.
//
// Optional feature (macro MC_SEQ_MISALIGN_TRAP_EN):
//   defined     : a taken target with addr[1:0]!=0 in WB goes to ERR, sets the
//                 sticky o_misalign output and suppresses the write/retire.
//   not defined : target bits [1:0] are forced to zero, no o_misalign port.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr     fetch request and address (= o_pc)
//   i_imem_ack/i_imem_rdata    fetch completion and instruction word
//   o_instr                    instruction register to the decoder
//   i_insn_vld_dec, i_is_load, i_is_store, i_rd_wren_dec, i_pc_sel
//                              decoder outputs for the current IR
//   i_alu_data                 branch/jump target or ALU result
//   o_dmem_req/o_dmem_we       data access request, 1=store
//   i_dmem_ack                 data access completion
//   o_rd_wren                  regfile write enable (WB only)
//   o_pc/o_pc_four             current PC and PC+4
//   o_pc_debug/o_insn_vld      PC of the last retired insn, legal-retire pulse
//   o_retire_cnt               retired instruction count (wraps)
//   o_timeout                  sticky memory timeout flag
// -----------------------------------------------------------------------------
module mc_core_seq
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 255,
    parameter int              CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_imem_req,
    output logic [XLEN-1:0]  o_imem_addr,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    output logic [31:0]      o_instr,
    input  logic             i_insn_vld_dec,
    input  logic             i_is_load,
    input  logic             i_is_store,
    input  logic             i_rd_wren_dec,
    input  logic             i_pc_sel,
    input  logic [XLEN-1:0]  i_alu_data,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    input  logic             i_dmem_ack,
    output logic             o_rd_wren,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_pc_four,
    output logic [XLEN-1:0]  o_pc_debug,
    output logic             o_insn_vld,
    output logic [CNT_W-1:0] o_retire_cnt,
`ifdef MC_SEQ_MISALIGN_TRAP_EN
    output logic             o_misalign,
`endif
    output logic             o_timeout
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;

    logic            ir_load;
    logic            pc_load;
    logic            retire;
    logic            wait_en;
    logic            expire;
    logic            state_chg;
    logic            trap;
    logic            take_tgt;

    logic [XLEN-1:0] pc_debug_p1;
    logic            vld_p1;
    logic [CNT_W-1:0] retire_cnt_p1;
    logic            timeout_q;

    // Taken targets are word aligned by dropping the low two bits; the
    // sequential path wraps naturally at 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(
        input logic            take,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] tgt
    );
        return take ? (tgt & ~XLEN'(3)) : (pc + XLEN'(4));
    endfunction

    // An illegal instruction never redirects, whatever the decoder's pc_sel says.
    assign take_tgt = i_pc_sel & i_insn_vld_dec;

`ifdef MC_SEQ_MISALIGN_TRAP_EN
    assign trap = (state_q == WB) & take_tgt & (|i_alu_data[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Only FETCH and MEM have a request outstanding, so only they can wait.
    assign wait_en   = ((state_q == FETCH) & ~i_imem_ack) |
                       ((state_q == MEM)   & ~i_dmem_ack);
    assign state_chg = (state_d != state_q);

    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (state_chg),
        .i_wait   (wait_en),
        .o_expire (expire)
    );

    // Next-state and stage outputs. Requests are also gated by i_rst_n so they
    // drop the instant reset is asserted, not at the next edge.
    always_comb begin
        state_d    = state_q;
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_rd_wren  = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            FETCH: begin
                o_imem_req = i_rst_n;
                if (i_imem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end else if (expire) begin
                    state_d = ERR;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if ((i_is_load | i_is_store) & i_insn_vld_dec) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                o_dmem_req = i_rst_n;
                o_dmem_we  = i_rst_n & i_is_store;
                if (i_dmem_ack) begin
                    state_d = WB;
                end else if (expire) begin
                    state_d = ERR;
                end
            end
            WB: begin
                if (trap) begin
                    state_d = ERR;
                end else begin
                    o_rd_wren = i_rst_n & i_rd_wren_dec & i_insn_vld_dec;
                    pc_load   = 1'b1;
                    retire    = 1'b1;
                    state_d   = FETCH;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Stage register: FSM state, PC and instruction register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= i_imem_rdata;
            end
            if (pc_load) begin
                pc_q <= next_pc(take_tgt, pc_q, i_alu_data);
            end
        end
    end

    // Retire stage: one cycle behind WB
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_debug_p1   <= '0;
            vld_p1        <= 1'b0;
            retire_cnt_p1 <= '0;
            timeout_q     <= 1'b0;
        end else begin
            vld_p1 <= retire & i_insn_vld_dec;
            if (retire) begin
                pc_debug_p1   <= pc_q;
                retire_cnt_p1 <= retire_cnt_p1 + CNT_W'(1);
            end
            if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef MC_SEQ_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign_q <= 1'b0;
        end else if (trap) begin
            misalign_q <= 1'b1;
        end
    end

    assign o_misalign = misalign_q;
`endif

    assign o_pc         = pc_q;
    assign o_imem_addr  = pc_q;
    assign o_pc_four    = pc_q + XLEN'(4);
    assign o_instr      = ir_q;
    assign o_pc_debug   = pc_debug_p1;
    assign o_insn_vld   = vld_p1;
    assign o_retire_cnt = retire_cnt_p1;
    assign o_timeout    = timeout_q;

endmodule
